mult_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one booth_multiplication instance (8x8 signed operands, 16-bit product, start/busy handshake) among NREQ requesters.
- Accepts operand pairs from requesters and drives the multiplier's start pulse.
- Tracks busy to completion, then returns the product tagged with the requester ID.
- Sits between client blocks and the single multiplier datapath.

---
 rtl/mult_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_mult_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter and sequencer sharing one 8x8 signed multiplier
// (start/busy handshake) among NREQ requesters.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req[NREQ]           per-requester request level, held until its gnt bit
//   a_in, b_in          8-bit operand slices, slice i belongs to requester i
//   gnt[NREQ]           one-hot grant pulse, operands captured on that edge
//   rsp_valid           one-cycle response pulse
//   rsp_id, rsp_ab      requester index and signed product of the response
//   rsp_err             timeout flag, qualified by rsp_valid
//   idle                high while the sequencer is idle
//   mul_a, mul_b        registered multiplier operands
//   mul_start           multiplier start, held START_CYC cycles
//   mul_busy, mul_ab    multiplier busy and product
//
// Optional feature: define MULT_ARB_TIMEOUT_EN to enable a TIMEOUT_CYC watchdog over the
// busy phases; an expired operation returns rsp_err=1 with rsp_ab=0.
module mult_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned IDW         = 2,
    parameter int unsigned START_CYC   = 1,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] a_in,
    input  logic [8*NREQ-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_ab,
    output logic              rsp_err,
    output logic              idle,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    output logic              mul_start,
    input  logic              mul_busy,
    input  logic [15:0]       mul_ab
);

    localparam int unsigned PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || IDW < PW || START_CYC < 1 || START_CYC > 15 ||
        TIMEOUT_CYC < 1) begin : g_bad_param
        $error("mult_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]    cur_id_q, cur_id_d;
    logic [3:0]        start_cnt_q, start_cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              mul_start_q, mul_start_d;
    logic [7:0]        mul_a_q, mul_a_d;
    logic [7:0]        mul_b_q, mul_b_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [15:0]       rsp_ab_q, rsp_ab_d;

    logic              sel_found;
    logic [PW-1:0]     sel_k;
    logic [PW-1:0]     idx;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           rsp_err_q, rsp_err_d;
    logic           to_expire;

    // Counter holds cycles already spent waiting; this edge makes it reach TIMEOUT_CYC.
    assign to_expire = (to_cnt_q == ToW'(TIMEOUT_CYC - 1));
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

    // First requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        sel_found = 1'b0;
        sel_k     = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = PW'((32'(ptr_q) + i) % NREQ);
            if (!sel_found && req[idx]) begin
                sel_found = 1'b1;
                sel_k     = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cur_id_d    = cur_id_q;
        start_cnt_d = start_cnt_q;
        gnt_d       = '0;
        mul_start_d = mul_start_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_ab_d    = rsp_ab_q;
`ifdef MULT_ARB_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
        to_cnt_d    = to_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    gnt_d       = NREQ'(1) << sel_k;
                    mul_a_d     = a_in[32'(sel_k)*8 +: 8];
                    mul_b_d     = b_in[32'(sel_k)*8 +: 8];
                    cur_id_d    = IDW'(sel_k);
                    mul_start_d = 1'b1;
                    start_cnt_d = 4'(START_CYC - 1);
                    ptr_d       = PW'((32'(sel_k) + 1) % NREQ);
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (start_cnt_q == 4'd0) begin
                    mul_start_d = 1'b0;
                    state_d     = StWaitBusy;
`ifdef MULT_ARB_TIMEOUT_EN
                    to_cnt_d    = '0;
`endif
                end else begin
                    start_cnt_d = start_cnt_q - 4'd1;
                end
            end
            StWaitBusy: begin
                if (mul_busy) begin
                    state_d = StWaitDone;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                to_cnt_d = to_cnt_q + 1'b1;
                if (to_expire) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_ab_d    = '0;
                    rsp_id_d    = cur_id_q;
                    state_d     = StIdle;
                end
`endif
            end
            StWaitDone: begin
`ifdef MULT_ARB_TIMEOUT_EN
                to_cnt_d = to_cnt_q + 1'b1;
`endif
                // A busy fall in the expiry cycle still yields a normal response.
                if (!mul_busy) begin
                    rsp_valid_d = 1'b1;
                    rsp_ab_d    = mul_ab;
                    rsp_id_d    = cur_id_q;
`ifdef MULT_ARB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = StIdle;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (to_expire) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_ab_d    = '0;
                    rsp_id_d    = cur_id_q;
                    state_d     = StIdle;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            cur_id_q    <= '0;
            start_cnt_q <= '0;
            gnt_q       <= '0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_ab_q    <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cur_id_q    <= cur_id_d;
            start_cnt_q <= start_cnt_d;
            gnt_q       <= gnt_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_ab_q    <= rsp_ab_d;
`ifdef MULT_ARB_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_ab    = rsp_ab_q;
    assign idle      = (state_q == StIdle);

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier, requesters that drop req after gnt,
// and a response scoreboard filled when requests are driven.
module tb_mult_arbiter;

    localparam int NREQ        = 4;
    localparam int IDW         = 2;
    localparam int START_CYC   = 2;
    localparam int TIMEOUT_CYC = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [8*NREQ-1:0]   a_in = '0;
    logic [8*NREQ-1:0]   b_in = '0;
    logic [NREQ-1:0]     gnt;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [15:0]         rsp_ab;
    logic                rsp_err;
    logic                idle;
    logic [7:0]          mul_a;
    logic [7:0]          mul_b;
    logic                mul_start;
    logic                mul_busy;
    logic [15:0]         mul_ab;

    mult_arbiter #(
        .NREQ(NREQ),
        .IDW(IDW),
        .START_CYC(START_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .a_in(a_in),
        .b_in(b_in),
        .gnt(gnt),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_ab(rsp_ab),
        .rsp_err(rsp_err),
        .idle(idle),
        .mul_a(mul_a),
        .mul_b(mul_b),
        .mul_start(mul_start),
        .mul_busy(mul_busy),
        .mul_ab(mul_ab)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    ab;
        logic           err;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   rsp_cnt = 0;
    int   n_exp_rsp = 0;
    bit   stuck = 1'b0;

    // Multiplier model: busy rises one cycle after mul_start falls, lasts 3 cycles.
    int   sa, sbv, mlat;
    logic start_prev;
    assign sa  = int'($signed(mul_a));
    assign sbv = int'($signed(mul_b));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_busy   <= 1'b0;
            mul_ab     <= '0;
            start_prev <= 1'b0;
            mlat       <= 0;
        end else begin
            start_prev <= mul_start;
            if (start_prev && !mul_start && !stuck) begin
                mul_busy <= 1'b1;
                mlat     <= 3;
                mul_ab   <= 16'(sa * sbv);
            end else if (mul_busy) begin
                if (mlat == 1) mul_busy <= 1'b0;
                mlat <= mlat - 1;
            end
        end
    end

    // Requesters drop their bit once granted.
    always @(posedge clk) begin
        #1;
        if (|gnt) req = req & ~gnt;
    end

    always @(negedge clk) if (rsp_valid) rsp_cnt++;

    task automatic push_exp(input int id, input int ab, input bit err);
        exp_t e;
        e.id  = IDW'(id);
        e.ab  = 16'(ab);
        e.err = err;
        sb.push_back(e);
        n_exp_rsp++;
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        a_in[i*8 +: 8] = 8'(a);
        b_in[i*8 +: 8] = 8'(b);
    endtask

    task automatic wait_rsp(output bit got);
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_total++; if (gnt !== 4'b0) $display("FAIL rst_gnt got %b want 0", gnt); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", rsp_valid); else n_pass++;
        n_total++; if (mul_start !== 1'b0) $display("FAIL rst_start got %b want 0", mul_start); else n_pass++;
        n_total++; if ({mul_a, mul_b, rsp_ab} !== 32'h0) $display("FAIL rst_data got %h want 0", {mul_a, mul_b, rsp_ab}); else n_pass++;
        n_total++; if ({rsp_id, rsp_err} !== 3'b0) $display("FAIL rst_id_err got %b want 0", {rsp_id, rsp_err}); else n_pass++;
        n_total++; if (idle !== 1'b1) $display("FAIL rst_idle got %b want 1", idle); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_contention();
        bit got;
        exp_t e;
        for (int i = 0; i < NREQ; i++) begin
            set_ops(i, i + 1, 3);
            push_exp(i, (i + 1) * 3, 1'b0);
        end
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            wait_rsp(got);
            n_total++;
            if (!got) begin
                $display("FAIL cont_timeout_%0d got no rsp want rsp", i);
                return;
            end
            n_pass++;
            e = sb.pop_front();
            n_total++; if (rsp_id !== e.id) $display("FAIL cont_id_%0d got %0d want %0d", i, rsp_id, e.id); else n_pass++;
            n_total++; if (rsp_ab !== e.ab) $display("FAIL cont_ab_%0d got %h want %h", i, rsp_ab, e.ab); else n_pass++;
            if (i < NREQ - 1) begin
                @(negedge clk);
                n_total++;
                if (gnt !== 4'(1 << (i + 1))) $display("FAIL back_to_back_%0d got %b want %b", i, gnt, 4'(1 << (i + 1)));
                else n_pass++;
            end
        end
    endtask

    task automatic test_single();
        bit got;
        exp_t e;
        int n;
        set_ops(0, 5, 10);
        push_exp(0, 50, 1'b0);
        req = 4'b0001;
        @(negedge clk);
        n_total++; if (gnt !== 4'b0001) $display("FAIL single_gnt got %b want 0001", gnt); else n_pass++;
        n_total++; if ({mul_a, mul_b} !== 16'h050A) $display("FAIL single_ops got %h want 050a", {mul_a, mul_b}); else n_pass++;
        n_total++; if (idle !== 1'b0) $display("FAIL single_busy_idle got %b want 0", idle); else n_pass++;
        n = mul_start ? 1 : 0;
        @(negedge clk);
        n_total++; if (gnt !== 4'b0) $display("FAIL single_gnt_pulse got %b want 0", gnt); else n_pass++;
        for (int k = 0; k < 20 && mul_start; k++) begin
            n++;
            @(negedge clk);
        end
        n_total++; if (n !== START_CYC) $display("FAIL single_start_len got %0d want %0d", n, START_CYC); else n_pass++;
        wait_rsp(got);
        n_total++;
        if (!got) begin
            $display("FAIL single_timeout got no rsp want rsp");
            return;
        end
        n_pass++;
        e = sb.pop_front();
        n_total++; if (rsp_ab !== e.ab) $display("FAIL single_ab got %h want %h", rsp_ab, e.ab); else n_pass++;
        n_total++; if (rsp_id !== e.id) $display("FAIL single_id got %0d want %0d", rsp_id, e.id); else n_pass++;
        @(negedge clk);
        n_total++; if ({rsp_valid, idle} !== 2'b01) $display("FAIL single_after got %b want 01", {rsp_valid, idle}); else n_pass++;
    endtask

    task automatic test_signed();
        bit got;
        exp_t e;
        set_ops(1, 8, -7);
        push_exp(1, -56, 1'b0);
        req = 4'b0010;
        wait_rsp(got);
        n_total++;
        if (!got) begin
            $display("FAIL signed_timeout got no rsp want rsp");
            return;
        end
        n_pass++;
        e = sb.pop_front();
        n_total++; if (rsp_ab !== e.ab) $display("FAIL signed_ab got %h want %h", rsp_ab, e.ab); else n_pass++;
        n_total++; if (rsp_id !== e.id) $display("FAIL signed_id got %0d want %0d", rsp_id, e.id); else n_pass++;
        n_total++; if (rsp_err !== e.err) $display("FAIL signed_err got %b want %b", rsp_err, e.err); else n_pass++;
    endtask

    task automatic test_rr_wrap();
        bit got;
        exp_t e;
        set_ops(2, -3, -4);
        push_exp(2, 12, 1'b0);
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            wait_rsp(got);
            n_total++;
            if (!got) begin
                $display("FAIL wrap_timeout_%0d got no rsp want rsp", i);
                return;
            end
            n_pass++;
            e = sb.pop_front();
            n_total++; if (rsp_id !== e.id) $display("FAIL wrap_id_%0d got %0d want %0d", i, rsp_id, e.id); else n_pass++;
            n_total++; if (rsp_ab !== e.ab) $display("FAIL wrap_ab_%0d got %h want %h", i, rsp_ab, e.ab); else n_pass++;
            if (i == 0) begin
                @(negedge clk);
                set_ops(3, 127, -128);
                set_ops(0, -128, -128);
                push_exp(3, -16256, 1'b0);
                push_exp(0, 16384, 1'b0);
                req = 4'b1001;
            end
        end
    endtask

`ifdef MULT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        bit seen;
        int n;
        stuck = 1'b1;
        set_ops(1, 17, 34);
        push_exp(1, 0, 1'b1);
        req = 4'b0010;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mul_start) seen = 1'b1;
            else if (seen) break;
        end
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
        end
        n_total++; if (n !== TIMEOUT_CYC) $display("FAIL to_latency got %0d want %0d", n, TIMEOUT_CYC); else n_pass++;
        e = sb.pop_front();
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL to_valid got %b want 1", rsp_valid); else n_pass++;
        n_total++; if (rsp_err !== e.err) $display("FAIL to_err got %b want %b", rsp_err, e.err); else n_pass++;
        n_total++; if (rsp_ab !== e.ab) $display("FAIL to_ab got %h want %h", rsp_ab, e.ab); else n_pass++;
        n_total++; if (rsp_id !== e.id) $display("FAIL to_id got %0d want %0d", rsp_id, e.id); else n_pass++;
        stuck = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid_op();
        bit got;
        exp_t e;
        int c0;
        set_ops(0, 7, 9);
        req = 4'b0001;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (mul_busy) got = 1'b1;
        end
        n_total++; if (!got) $display("FAIL rmo_busy got 0 want 1"); else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++; if ({gnt, rsp_valid, mul_start} !== 6'b0) $display("FAIL rmo_ctl got %b want 0", {gnt, rsp_valid, mul_start}); else n_pass++;
        n_total++; if ({mul_a, mul_b, rsp_ab} !== 32'h0) $display("FAIL rmo_data got %h want 0", {mul_a, mul_b, rsp_ab}); else n_pass++;
        n_total++; if (idle !== 1'b1) $display("FAIL rmo_idle got %b want 1", idle); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c0 = rsp_cnt;
        repeat (10) @(negedge clk);
        n_total++; if (rsp_cnt !== c0) $display("FAIL rmo_no_rsp got %0d want %0d", rsp_cnt, c0); else n_pass++;
        set_ops(2, 6, -5);
        push_exp(2, -30, 1'b0);
        req = 4'b0100;
        wait_rsp(got);
        n_total++;
        if (!got) begin
            $display("FAIL rmo_timeout got no rsp want rsp");
            return;
        end
        n_pass++;
        e = sb.pop_front();
        n_total++; if (rsp_id !== e.id) $display("FAIL rmo_id got %0d want %0d", rsp_id, e.id); else n_pass++;
        n_total++; if (rsp_ab !== e.ab) $display("FAIL rmo_ab got %h want %h", rsp_ab, e.ab); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_signed();
        test_rr_wrap();
`ifdef MULT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_op();
        repeat (5) @(negedge clk);
        n_total++; if (rsp_cnt !== n_exp_rsp) $display("FAIL rsp_count got %0d want %0d", rsp_cnt, n_exp_rsp); else n_pass++;
        n_total++; if (sb.size() !== 0) $display("FAIL sb_empty got %0d want 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
